rob: RTL and testbench

- Reorder buffer: consumer end of the RS/LSB result broadcast and producer of `rob_clear`.
- Allocates an entry per decoded instruction and returns its id as `Qdest`.
- Captures results from the RS and LSB buses, answers decoder operand lookups, and retires in program order.
- At commit it writes the register file, releases stores to the LSB, and flushes the pipeline on a misprediction.

---
 rtl/rob.sv | 223 ++++++++++++++++++++++
 tb/tb_rob.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob.sv
// Reorder buffer: allocates ids at issue, collects RS/LSB results, retires in
// program order and raises rob_clear on branch/JALR mispredictions.
module rob #(
  parameter int ROB_SIZE = 16,
  parameter int ROB_W    = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             is_dc,
  input  logic [1:0]       dc_type,
  input  logic [4:0]       dc_rd,
  input  logic             dc_ready,
  input  logic [31:0]      dc_val,
  input  logic [31:0]      dc_alt_pc,
  input  logic             dc_pred_taken,
  output logic [ROB_W-1:0] rob_tail,
  output logic             rob_full,
  input  logic [ROB_W-1:0] q1_id,
  input  logic [ROB_W-1:0] q2_id,
  output logic             q1_ready,
  output logic             q2_ready,
  output logic [31:0]      q1_val,
  output logic [31:0]      q2_val,
  input  logic             rs_has_output,
  input  logic [ROB_W-1:0] rs_rob_id,
  input  logic [31:0]      rs_output,
  input  logic             has_jalr_new_pc,
  input  logic [31:0]      jalr_new_pc,
  input  logic             is_lsb,
  input  logic [ROB_W-1:0] lsb_rob_id,
  input  logic [31:0]      lsb_res,
  output logic             commit_reg,
  output logic [4:0]       commit_rd,
  output logic [31:0]      commit_val,
  output logic [ROB_W-1:0] commit_id,
  output logic             commit_store,
  output logic             rob_clear,
  output logic [31:0]      clear_pc
);
  localparam logic [1:0] T_REG    = 2'd0;
  localparam logic [1:0] T_STORE  = 2'd1;
  localparam logic [1:0] T_BRANCH = 2'd2;
  localparam logic [1:0] T_JALR   = 2'd3;
  localparam int CNT_W = ROB_W + 1;

  logic [ROB_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ROB_SIZE-1:0] busy_q, busy_d, ready_q, ready_d, pred_q, pred_d;
  logic [1:0]          type_q [ROB_SIZE];
  logic [1:0]          type_d [ROB_SIZE];
  logic [4:0]          rd_q   [ROB_SIZE];
  logic [4:0]          rd_d   [ROB_SIZE];
  logic [31:0]         val_q  [ROB_SIZE];
  logic [31:0]         val_d  [ROB_SIZE];
  logic [31:0]         alt_q  [ROB_SIZE];
  logic [31:0]         alt_d  [ROB_SIZE];
  logic [31:0]         jtgt_q [ROB_SIZE];
  logic [31:0]         jtgt_d [ROB_SIZE];

  logic             commit_reg_q, commit_reg_d, commit_store_q, commit_store_d;
  logic             clear_q, clear_d;
  logic [31:0]      clear_pc_q, clear_pc_d, commit_val_q, commit_val_d;
  logic [4:0]       commit_rd_q, commit_rd_d;
  logic [ROB_W-1:0] commit_id_q, commit_id_d;
  logic             do_issue, do_commit;

  always_comb begin
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    busy_d         = busy_q;
    ready_d        = ready_q;
    pred_d         = pred_q;
    type_d         = type_q;
    rd_d           = rd_q;
    val_d          = val_q;
    alt_d          = alt_q;
    jtgt_d         = jtgt_q;
    commit_reg_d   = 1'b0;
    commit_store_d = 1'b0;
    clear_d        = 1'b0;
    clear_pc_d     = clear_pc_q;
    commit_rd_d    = commit_rd_q;
    commit_val_d   = commit_val_q;
    commit_id_d    = commit_id_q;
    do_issue       = is_dc && (count_q != CNT_W'(ROB_SIZE)) && !clear_q;
    do_commit      = busy_q[head_q] && ready_q[head_q] && !clear_q;

    if (clear_q) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      busy_d  = '0;
    end else begin
      if (rs_has_output && busy_q[rs_rob_id]) begin
        ready_d[rs_rob_id] = 1'b1;
        val_d[rs_rob_id]   = rs_output;
        if (has_jalr_new_pc) jtgt_d[rs_rob_id] = jalr_new_pc;
      end
      if (is_lsb && busy_q[lsb_rob_id]) begin
        ready_d[lsb_rob_id] = 1'b1;
        val_d[lsb_rob_id]   = lsb_res;
      end
      if (do_commit) begin
        busy_d[head_q] = 1'b0;
        head_d         = head_q + ROB_W'(1);
        commit_id_d    = head_q;
        commit_rd_d    = rd_q[head_q];
        commit_val_d   = val_q[head_q];
        case (type_q[head_q])
          T_REG:   commit_reg_d = 1'b1;
          T_STORE: commit_store_d = 1'b1;
          T_BRANCH: begin
            if (val_q[head_q][0] != pred_q[head_q]) begin
              clear_d    = 1'b1;
              clear_pc_d = alt_q[head_q];
            end
          end
          default: begin
            commit_reg_d = 1'b1;
            if (jtgt_q[head_q] != alt_q[head_q]) begin
              clear_d    = 1'b1;
              clear_pc_d = jtgt_q[head_q];
            end
          end
        endcase
      end
      // jalr target defaults to the prediction so a JALR without a new pc never flushes
      if (do_issue) begin
        busy_d[tail_q]  = 1'b1;
        ready_d[tail_q] = dc_ready || (dc_type == T_STORE);
        type_d[tail_q]  = dc_type;
        rd_d[tail_q]    = dc_rd;
        val_d[tail_q]   = dc_val;
        alt_d[tail_q]   = dc_alt_pc;
        jtgt_d[tail_q]  = dc_alt_pc;
        pred_d[tail_q]  = dc_pred_taken;
        tail_d          = tail_q + ROB_W'(1);
      end
      case ({do_issue, do_commit})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      busy_q         <= '0;
      ready_q        <= '0;
      commit_reg_q   <= 1'b0;
      commit_store_q <= 1'b0;
      clear_q        <= 1'b0;
      clear_pc_q     <= '0;
      commit_rd_q    <= '0;
      commit_val_q   <= '0;
      commit_id_q    <= '0;
    end else if (rdy_in) begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      pred_q         <= pred_d;
      type_q         <= type_d;
      rd_q           <= rd_d;
      val_q          <= val_d;
      alt_q          <= alt_d;
      jtgt_q         <= jtgt_d;
      commit_reg_q   <= commit_reg_d;
      commit_store_q <= commit_store_d;
      clear_q        <= clear_d;
      clear_pc_q     <= clear_pc_d;
      commit_rd_q    <= commit_rd_d;
      commit_val_q   <= commit_val_d;
      commit_id_q    <= commit_id_d;
    end
  end

  always_comb begin
    q1_ready = ready_q[q1_id];
    q1_val   = val_q[q1_id];
    if (!ready_q[q1_id]) begin
      if (rs_has_output && rs_rob_id == q1_id) begin
        q1_ready = 1'b1;
        q1_val   = rs_output;
      end else if (is_lsb && lsb_rob_id == q1_id) begin
        q1_ready = 1'b1;
        q1_val   = lsb_res;
      end
    end
  end

  always_comb begin
    q2_ready = ready_q[q2_id];
    q2_val   = val_q[q2_id];
    if (!ready_q[q2_id]) begin
      if (rs_has_output && rs_rob_id == q2_id) begin
        q2_ready = 1'b1;
        q2_val   = rs_output;
      end else if (is_lsb && lsb_rob_id == q2_id) begin
        q2_ready = 1'b1;
        q2_val   = lsb_res;
      end
    end
  end

  // pulses are held across a stall and shown once rdy_in returns
  assign commit_reg   = commit_reg_q & rdy_in;
  assign commit_store = commit_store_q & rdy_in;
  assign rob_clear    = clear_q & rdy_in;
  assign clear_pc     = clear_pc_q;
  assign commit_rd    = commit_rd_q;
  assign commit_val   = commit_val_q;
  assign commit_id    = commit_id_q;
  assign rob_tail     = tail_q;
  assign rob_full     = ({1'b0, count_q} + (CNT_W+1)'(2)) >= (CNT_W+1)'(ROB_SIZE);
endmodule

// File: tb/tb_rob.sv
// Bench for rob: directed issue/writeback sequences; expected commit events are
// queued with the stimulus and matched by a negedge monitor.
module tb_rob;
  localparam int ROB_SIZE = 16;
  localparam int ROB_W    = 4;
  localparam logic [1:0] T_REG = 2'd0, T_STORE = 2'd1, T_BRANCH = 2'd2, T_JALR = 2'd3;

  logic             clk_in = 1'b0;
  logic             rst_in, rdy_in, is_dc, dc_ready, dc_pred_taken;
  logic [1:0]       dc_type;
  logic [4:0]       dc_rd;
  logic [31:0]      dc_val, dc_alt_pc;
  logic [ROB_W-1:0] rob_tail, q1_id, q2_id, rs_rob_id, lsb_rob_id, commit_id;
  logic             rob_full, q1_ready, q2_ready;
  logic [31:0]      q1_val, q2_val, rs_output, jalr_new_pc, lsb_res, commit_val, clear_pc;
  logic             rs_has_output, has_jalr_new_pc, is_lsb;
  logic             commit_reg, commit_store, rob_clear;
  logic [4:0]       commit_rd;

  typedef struct packed {
    logic        reg_w;
    logic        st;
    logic        clr;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [3:0]  id;
    logic [31:0] pc;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk_in = ~clk_in;

  rob #(.ROB_SIZE(ROB_SIZE), .ROB_W(ROB_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .is_dc(is_dc), .dc_type(dc_type), .dc_rd(dc_rd), .dc_ready(dc_ready),
    .dc_val(dc_val), .dc_alt_pc(dc_alt_pc), .dc_pred_taken(dc_pred_taken),
    .rob_tail(rob_tail), .rob_full(rob_full),
    .q1_id(q1_id), .q2_id(q2_id), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_val(q1_val), .q2_val(q2_val),
    .rs_has_output(rs_has_output), .rs_rob_id(rs_rob_id), .rs_output(rs_output),
    .has_jalr_new_pc(has_jalr_new_pc), .jalr_new_pc(jalr_new_pc),
    .is_lsb(is_lsb), .lsb_rob_id(lsb_rob_id), .lsb_res(lsb_res),
    .commit_reg(commit_reg), .commit_rd(commit_rd), .commit_val(commit_val),
    .commit_id(commit_id), .commit_store(commit_store),
    .rob_clear(rob_clear), .clear_pc(clear_pc)
  );

  function automatic void chk(string name, logic [127:0] got, logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endfunction

  function automatic void push(logic r, logic s, logic c, logic [4:0] rd, logic [31:0] v,
                               logic [3:0] id, logic [31:0] pc);
    ev_t e;
    e.reg_w = r;
    e.st    = s;
    e.clr   = c;
    e.rd    = r ? rd : 5'd0;
    e.val   = r ? v : 32'd0;
    e.id    = (r | s) ? id : 4'd0;
    e.pc    = c ? pc : 32'd0;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk_in) begin
    ev_t g;
    ev_t w;
    if (!rst_in && (commit_reg || commit_store || rob_clear)) begin
      g.reg_w = commit_reg;
      g.st    = commit_store;
      g.clr   = rob_clear;
      g.rd    = commit_reg ? commit_rd : 5'd0;
      g.val   = commit_reg ? commit_val : 32'd0;
      g.id    = (commit_reg | commit_store) ? commit_id : 4'd0;
      g.pc    = rob_clear ? clear_pc : 32'd0;
      if (exp_q.size() == 0) begin
        chk("unexpected_commit", 128'(g), 128'(0));
      end else begin
        w = exp_q.pop_front();
        chk("commit", 128'(g), 128'(w));
      end
    end
  end

  task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic rdy,
                       input logic [31:0] v, input logic [31:0] alt, input logic pred);
    is_dc = 1'b1; dc_type = t; dc_rd = rd; dc_ready = rdy;
    dc_val = v; dc_alt_pc = alt; dc_pred_taken = pred;
    @(posedge clk_in); #1;
    is_dc = 1'b0; dc_ready = 1'b0;
  endtask

  task automatic rs_wb(input logic [3:0] id, input logic [31:0] v,
                       input logic j, input logic [31:0] jpc);
    rs_has_output = 1'b1; rs_rob_id = id; rs_output = v;
    has_jalr_new_pc = j; jalr_new_pc = jpc;
    @(posedge clk_in); #1;
    rs_has_output = 1'b0; has_jalr_new_pc = 1'b0;
  endtask

  task automatic drain(string name);
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk_in);
    chk(name, 128'(exp_q.size()), 128'(0));
    @(posedge clk_in); #1;
  endtask

  task automatic wait_clear(string name);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk_in);
      seen = rob_clear;
    end
    chk(name, 128'(seen), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; is_dc = 1'b0; dc_type = T_REG; dc_rd = '0;
    dc_ready = 1'b0; dc_val = '0; dc_alt_pc = '0; dc_pred_taken = 1'b0;
    q1_id = '0; q2_id = '0; rs_has_output = 1'b0; rs_rob_id = '0; rs_output = '0;
    has_jalr_new_pc = 1'b0; jalr_new_pc = '0; is_lsb = 1'b0; lsb_rob_id = '0; lsb_res = '0;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
    chk("reset_outputs", 128'({commit_reg, commit_store, rob_clear, clear_pc,
                                commit_rd, commit_val, commit_id}), 128'(0));
    chk("reset_tail", 128'(rob_tail), 128'(0));
    chk("reset_full", 128'(rob_full), 128'(0));

    // in-order retirement with out-of-order writeback
    for (int i = 0; i < 3; i++) begin
      chk("issue_tail", 128'(rob_tail), 128'(i));
      push(1'b1, 1'b0, 1'b0, 5'(i + 1), 32'h10 + 32'(i), 4'(i), 32'd0);
      issue(T_REG, 5'(i + 1), 1'b0, 32'd0, 32'd0, 1'b0);
    end
    rs_wb(4'd1, 32'h11, 1'b0, 32'd0);
    rs_wb(4'd0, 32'h10, 1'b0, 32'd0);
    rs_wb(4'd2, 32'h12, 1'b0, 32'd0);
    drain("inorder_drain");

    // fill to 14, full flag, release after one commit
    for (int i = 0; i < 14; i++) begin
      push(1'b1, 1'b0, 1'b0, 5'(i + 1), 32'h100 + 32'(i), 4'((3 + i) % 16), 32'd0);
      issue(T_REG, 5'(i + 1), 1'b0, 32'd0, 32'd0, 1'b0);
      if (i == 12) chk("full_at_13", 128'(rob_full), 128'(0));
    end
    chk("full_at_14", 128'(rob_full), 128'(1));
    rs_wb(4'd3, 32'h100, 1'b0, 32'd0);
    chk("full_before_commit", 128'(rob_full), 128'(1));
    @(posedge clk_in); #1;
    chk("full_after_commit", 128'(rob_full), 128'(0));
    for (int i = 1; i < 14; i++) rs_wb(4'((3 + i) % 16), 32'h100 + 32'(i), 1'b0, 32'd0);
    drain("full_drain");

    // stores at ids 1..4, then bypass lookups on ids 5 and 6
    for (int i = 0; i < 4; i++) begin
      push(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 4'(1 + i), 32'd0);
      issue(T_STORE, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    end
    push(1'b1, 1'b0, 1'b0, 5'd7, 32'hABCD, 4'd5, 32'd0);
    issue(T_REG, 5'd7, 1'b0, 32'd0, 32'd0, 1'b0);
    push(1'b1, 1'b0, 1'b0, 5'd8, 32'h5555, 4'd6, 32'd0);
    issue(T_REG, 5'd8, 1'b0, 32'd0, 32'd0, 1'b0);
    q1_id = 4'd5; q2_id = 4'd6;
    #1;
    chk("q1_not_ready", 128'(q1_ready), 128'(0));
    chk("q2_not_ready", 128'(q2_ready), 128'(0));
    rs_has_output = 1'b1; rs_rob_id = 4'd5; rs_output = 32'hABCD;
    is_lsb = 1'b1; lsb_rob_id = 4'd6; lsb_res = 32'h5555;
    #1;
    chk("q1_bypass", 128'({q1_ready, q1_val}), 128'({1'b1, 32'hABCD}));
    chk("q2_bypass", 128'({q2_ready, q2_val}), 128'({1'b1, 32'h5555}));
    @(posedge clk_in); #1;
    rs_has_output = 1'b0; is_lsb = 1'b0;
    #1;
    chk("q1_stored", 128'({q1_ready, q1_val}), 128'({1'b1, 32'hABCD}));
    chk("q2_stored", 128'({q2_ready, q2_val}), 128'({1'b1, 32'h5555}));
    drain("lookup_drain");

    // mispredicted branch at id7 flushes the two younger entries
    push(1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 4'd0, 32'h200);
    issue(T_BRANCH, 5'd0, 1'b0, 32'd0, 32'h200, 1'b0);
    issue(T_REG, 5'd9, 1'b0, 32'd0, 32'd0, 1'b0);
    issue(T_REG, 5'd10, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("branch_tail", 128'(rob_tail), 128'(10));
    rs_wb(4'd7, 32'd1, 1'b0, 32'd0);
    wait_clear("branch_clear");
    is_dc = 1'b1; dc_type = T_REG; dc_ready = 1'b1; dc_rd = 5'd11; dc_val = 32'h99;
    @(posedge clk_in); #1;
    is_dc = 1'b0; dc_ready = 1'b0;
    chk("flush_tail", 128'(rob_tail), 128'(0));
    chk("flush_full", 128'(rob_full), 128'(0));

    // JALR: wrong then right target prediction
    push(1'b1, 1'b0, 1'b1, 5'd1, 32'h44, 4'd0, 32'h180);
    issue(T_JALR, 5'd1, 1'b0, 32'd0, 32'h100, 1'b0);
    rs_wb(4'd0, 32'h44, 1'b1, 32'h180);
    wait_clear("jalr_clear");
    @(posedge clk_in); #1;
    chk("jalr_flush_tail", 128'(rob_tail), 128'(0));
    push(1'b1, 1'b0, 1'b0, 5'd1, 32'h44, 4'd0, 32'd0);
    issue(T_JALR, 5'd1, 1'b0, 32'd0, 32'h100, 1'b0);
    rs_wb(4'd0, 32'h44, 1'b1, 32'h100);
    drain("jalr_ok_drain");
    issue(T_BRANCH, 5'd0, 1'b0, 32'd0, 32'h300, 1'b1);
    rs_wb(4'd1, 32'd1, 1'b0, 32'd0);
    repeat (4) @(posedge clk_in);
    #1;
    chk("branch_ok_tail", 128'(rob_tail), 128'(2));

    // 40 entries with interleaved stores: head and tail wrap twice
    for (int i = 0; i < 40; i++) begin
      chk("wrap_tail", 128'(rob_tail), 128'((2 + i) % 16));
      if (i % 3 == 0) begin
        push(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 4'((2 + i) % 16), 32'd0);
        issue(T_STORE, 5'd0, 1'b0, 32'h1000 + 32'(i), 32'd0, 1'b0);
      end else begin
        push(1'b1, 1'b0, 1'b0, 5'(i % 31 + 1), 32'h1000 + 32'(i), 4'((2 + i) % 16), 32'd0);
        issue(T_REG, 5'(i % 31 + 1), 1'b1, 32'h1000 + 32'(i), 32'd0, 1'b0);
      end
    end
    drain("wrap_drain");

    // rdy_in low freezes issue and writeback
    issue(T_REG, 5'd5, 1'b0, 32'd0, 32'd0, 1'b0);
    rdy_in = 1'b0;
    is_dc = 1'b1; dc_type = T_REG; dc_ready = 1'b1; dc_rd = 5'd6;
    rs_has_output = 1'b1; rs_rob_id = 4'd10; rs_output = 32'h77;
    @(posedge clk_in); #1;
    rdy_in = 1'b1; is_dc = 1'b0; dc_ready = 1'b0; rs_has_output = 1'b0;
    chk("stall_tail", 128'(rob_tail), 128'(11));
    q1_id = 4'd10;
    #1;
    chk("stall_no_wb", 128'(q1_ready), 128'(0));

    // reset mid-stream
    issue(T_REG, 5'd12, 1'b0, 32'd0, 32'd0, 1'b0);
    issue(T_REG, 5'd13, 1'b0, 32'd0, 32'd0, 1'b0);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    chk("rst_tail", 128'(rob_tail), 128'(0));
    chk("rst_full", 128'(rob_full), 128'(0));
    chk("rst_outputs", 128'({commit_reg, commit_store, rob_clear}), 128'(0));
    push(1'b1, 1'b0, 1'b0, 5'd3, 32'hBEEF, 4'd0, 32'd0);
    issue(T_REG, 5'd3, 1'b1, 32'hBEEF, 32'd0, 1'b0);
    drain("post_reset_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
